interface_adc16bits: RTL and testbench
======================================

INTERFACE_ADC16BITS -- requirements
Module: interface_adc16bits

Interface
REQ-001 SHALL provide parameter NB_BITS, default 16: serial word length, and audio_out width.
REQ-002 SHALL provide parameter DIV_SCLK, default 2: clk_in cycles per SCLK half-period, legal range 1..15.
REQ-003 SHALL have port clk_in, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port nv_echantillon1, input, 1: conversion request, level-sampled each clk_in edge.
REQ-006 SHALL have port audio_in, input, 1: serial data from the ADC, MSB first.
REQ-007 SHALL have port SCLK, output, 1: serial clock generated from a clk_in divider (never gated clk_in); idles high.
REQ-008 SHALL have port sync, output, 1: active-low frame/chip-select; idles high.
REQ-009 SHALL have port audio_out, output, NB_BITS: last received sample, held until the next completed frame.
REQ-010 SHALL have port echantillon_pret, output, 1: one-cycle strobe; audio_out is valid in this cycle.
REQ-011 SHALL have port occupe, output, 1: high from request acceptance until return to REPOS.
REQ-012 SHALL have port debordement, output, 1: one-cycle pulse when a request arrives while occupe=1.

Function
REQ-013 SHALL implement FSM states REPOS, CONVERSION, FIN.
REQ-014 In REPOS, nv_echantillon1=1 SHALL be accepted (cycle T); the FSM enters CONVERSION and occupe=1 from T+1.
REQ-015 At T+1, sync SHALL go 0 and SCLK SHALL go 0.
REQ-016 SCLK SHALL toggle every DIV_SCLK cycles thereafter, giving NB_BITS full periods.
REQ-017 Bit k (k=0 is MSB) SHALL be sampled from audio_in on the clk_in edge where SCLK rises, at T+1+(2k+1)*DIV_SCLK.
REQ-018 The shift register SHALL shift left, inserting at the LSB; a bit counter SHALL track the received bits, and no bit beyond NB_BITS SHALL be sampled.
REQ-019 At T+1+NB_BITS*2*DIV_SCLK, sync SHALL return to 1, SCLK SHALL be 1, audio_out SHALL update, echantillon_pret SHALL pulse, and the FSM SHALL enter FIN.
REQ-020 FIN SHALL last DIV_SCLK cycles with sync=1 (ADC quiet time), then return to REPOS; occupe SHALL drop on entry to REPOS.
REQ-021 A request in REPOS on the cycle FIN exits SHALL NOT be accepted until the following cycle (it is seen in REPOS).
REQ-022 A request while occupe=1 SHALL be ignored and SHALL pulse debordement for each cycle it is held.
REQ-023 audio_out SHALL NOT change outside an echantillon_pret cycle.

Reset
REQ-024 With reset=0 at a clk_in edge, the following SHALL take effect: FSM=REPOS, SCLK=1, sync=1, audio_out=0, echantillon_pret=0, occupe=0, debordement=0, shift register and counters=0.
REQ-025 Reset mid-CONVERSION SHALL abort the frame with no echantillon_pret; sync SHALL rise on the reset edge, and a partial word SHALL never reach audio_out.
REQ-026 Requests SHALL NOT be accepted on a cycle where reset=0.

Configuration
REQ-027 Macro ADC_SIGNE_EN defined: audio_out SHALL be the received offset-binary word with the MSB inverted, giving two's complement (inverse of the DAC path mapping).
REQ-028 Macro ADC_SIGNE_EN undefined: audio_out SHALL be the raw received word, unmodified.

Structure
REQ-029 A shared package SHALL hold FSM state encoding (REPOS, CONVERSION, FIN), the NB_BITS default, and the offset-binary MSB mask constant.
REQ-030 A sub-module gen_sclk SHALL hold the divider and rise/fall edge-enable generation; the FSM and shift register SHALL stay in the top.

Verification
REQ-031 ADC model drives 0x8000, ADC_SIGNE_EN set, DIV_SCLK=2 -> audio_out=0x0000; echantillon_pret exactly at T+65; sync low for 64 cycles.
REQ-032 ADC drives 0xFFFF then 0x0000, ADC_SIGNE_EN set -> audio_out 0x7FFF then 0x8000.
REQ-033 ADC drives 0x1234, ADC_SIGNE_EN undefined -> audio_out=0x1234; 16 SCLK rising edges counted inside the sync low window.
REQ-034 nv_echantillon1 held high continuously -> debordement pulses while occupe=1; next frame accepted the cycle after REPOS is entered; frames separated by ≥DIV_SCLK+1 cycles of sync=1.
REQ-035 reset=0 asserted at the 8th SCLK rise -> sync=1 and SCLK=1 next edge; no echantillon_pret; audio_out keeps 0; a following clean frame of 0xA5A5 returns the correct value.
REQ-036 DIV_SCLK=1 with pattern 0x0001 -> SCLK period 2 clk_in cycles; echantillon_pret at T+33; LSB captured.

Source files
------------

// File: rtl/interface_adc16bits_pkg.sv
// Shared types and constants for the 16-bit serial ADC front end.
package interface_adc16bits_pkg;

  typedef enum logic [1:0] {
    REPOS      = 2'd0,
    CONVERSION = 2'd1,
    FIN        = 2'd2
  } etat_t;

  localparam int NB_BITS_DEF = 16;
  localparam int DIV_W       = 4;   // wide enough for DIV_SCLK up to 15

  // Flipping the MSB maps offset-binary ADC codes onto two's complement.
  localparam logic [NB_BITS_DEF-1:0] MSB_MASK = 16'h8000;

endpackage

// File: rtl/interface_adc16bits_if.sv
// Handshake and serial bus between the ADC front end and its user / ADC chip.
interface interface_adc16bits_if
  import interface_adc16bits_pkg::*;
#(
  parameter int NB_BITS = NB_BITS_DEF
);
  logic               nv_echantillon1;
  logic               audio_in;
  logic               SCLK;
  logic               sync;
  logic [NB_BITS-1:0] audio_out;
  logic               echantillon_pret;
  logic               occupe;
  logic               debordement;

  modport master (
    output nv_echantillon1, audio_in,
    input  SCLK, sync, audio_out, echantillon_pret, occupe, debordement
  );

  modport slave (
    input  nv_echantillon1, audio_in,
    output SCLK, sync, audio_out, echantillon_pret, occupe, debordement
  );
endinterface

// File: rtl/interface_adc16bits_gen_sclk.sv
// SCLK divider: toggles every DIV_SCLK clk cycles while enabled, idles high,
// and flags the clk edges on which SCLK rises or falls.
module gen_sclk
  import interface_adc16bits_pkg::*;
#(
  parameter int DIV_SCLK = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic en,
  input  logic stop,
  output logic sclk,
  output logic rise,
  output logic fall
);
  logic [DIV_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == DIV_W'(DIV_SCLK - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (start) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (en) begin
      if (wrap) begin
        cnt  <= '0;
        // Last period ends high instead of falling, so SCLK parks at idle.
        sclk <= stop ? 1'b1 : ~sclk;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt  <= '0;
      sclk <= 1'b1;
    end
  end

  assign rise = en & wrap & ~sclk;
  assign fall = en & wrap &  sclk;

endmodule

// File: rtl/interface_adc16bits.sv
// Serial ADC reader: frames NB_BITS MSB-first bits under sync/SCLK and
// presents the word on audio_out. Define ADC_SIGNE_EN to output two's complement.
module interface_adc16bits
  import interface_adc16bits_pkg::*;
#(
  parameter int NB_BITS  = NB_BITS_DEF,
  parameter int DIV_SCLK = 2
) (
  input logic                  clk_in,
  input logic                  reset,
  interface_adc16bits_if.slave bus
);
  localparam int CNT_W = $clog2(NB_BITS + 1);
  localparam logic [NB_BITS-1:0] MASK =
    (NB_BITS == NB_BITS_DEF) ? NB_BITS'(MSB_MASK) : {1'b1, {(NB_BITS-1){1'b0}}};
`ifdef ADC_SIGNE_EN
  localparam bit SIGNE = 1'b1;
`else
  localparam bit SIGNE = 1'b0;
`endif
  localparam logic [NB_BITS-1:0] XOR_MASK = SIGNE ? MASK : '0;

  etat_t              state, state_nxt;
  logic               accept, frame_end, fin_done;
  logic               sclk, rise, fall;
  logic               sync, occupe;
  logic [NB_BITS-1:0] shreg, audio_q;
  logic [CNT_W-1:0]   bit_cnt;
  logic [DIV_W-1:0]   fin_cnt;
  logic               pret_q, debord_q;

  assign accept    = (state == REPOS) & bus.nv_echantillon1;
  // bit_cnt advances on each falling SCLK, i.e. after each received bit;
  // the fall that would follow the last bit closes the frame instead.
  assign frame_end = fall & (bit_cnt == CNT_W'(NB_BITS - 1));
  assign fin_done  = (fin_cnt == DIV_W'(DIV_SCLK - 1));

  gen_sclk #(.DIV_SCLK(DIV_SCLK)) u_gen_sclk (
    .clk   (clk_in),
    .reset (reset),
    .start (accept),
    .en    (state == CONVERSION),
    .stop  (frame_end),
    .sclk  (sclk),
    .rise  (rise),
    .fall  (fall)
  );

  always_ff @(posedge clk_in) begin
    if (!reset) state <= REPOS;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      REPOS:      if (bus.nv_echantillon1) state_nxt = CONVERSION;
      CONVERSION: if (frame_end)           state_nxt = FIN;
      FIN:        if (fin_done)            state_nxt = REPOS;
      default:                             state_nxt = REPOS;
    endcase
  end

  always_comb begin
    sync   = (state != CONVERSION);
    occupe = (state != REPOS);
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      fin_cnt  <= '0;
      audio_q  <= '0;
      pret_q   <= 1'b0;
      debord_q <= 1'b0;
    end else begin
      pret_q   <= 1'b0;
      debord_q <= bus.nv_echantillon1 & occupe;
      if (accept) begin
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (state == CONVERSION) begin
        if (rise && bit_cnt < CNT_W'(NB_BITS))
          shreg <= {shreg[NB_BITS-2:0], bus.audio_in};
        if (frame_end) begin
          audio_q <= shreg ^ XOR_MASK;
          pret_q  <= 1'b1;
        end else if (fall) begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (state == FIN) fin_cnt <= fin_cnt + 1'b1;
      else              fin_cnt <= '0;
    end
  end

  assign bus.SCLK             = sclk;
  assign bus.sync             = sync;
  assign bus.occupe           = occupe;
  assign bus.audio_out        = audio_q;
  assign bus.echantillon_pret = pret_q;
  assign bus.debordement      = debord_q;

endmodule

// File: tb/tb_interface_adc16bits.sv
// Directed bench: two DUTs (DIV_SCLK=2 and DIV_SCLK=1) fed by behavioural ADC models.
module tb_interface_adc16bits;

`ifdef ADC_SIGNE_EN
  localparam bit SIGNE = 1'b1;
`else
  localparam bit SIGNE = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic reset;
  always #5 clk_in = ~clk_in;

  interface_adc16bits_if #(.NB_BITS(16)) bus2();
  interface_adc16bits_if #(.NB_BITS(16)) bus1();

  interface_adc16bits #(.NB_BITS(16), .DIV_SCLK(2)) u_dut2 (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus2)
  );

  interface_adc16bits #(.NB_BITS(16), .DIV_SCLK(1)) u_dut1 (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus1)
  );

  bit          sel;
  logic [15:0] adc_word;
  wire         o_sync  = sel ? bus1.sync : bus2.sync;
  wire         o_sclk  = sel ? bus1.SCLK : bus2.SCLK;
  wire         o_pret  = sel ? bus1.echantillon_pret : bus2.echantillon_pret;
  wire         o_occ   = sel ? bus1.occupe : bus2.occupe;
  wire  [15:0] o_audio = sel ? bus1.audio_out : bus2.audio_out;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    bit          div1;
    logic [15:0] adc;
    logic [15:0] raw;
    logic [15:0] sgn;
    int          lat;
    int          slow;
  } vec_t;
  vec_t vt[6];

  // ADC models: present the next MSB-first bit after each SCLK fall inside sync low.
  initial begin : adc2
    int   idx;
    logic ps;
    idx = 0; ps = 1'b1; bus2.audio_in = 1'b0;
    forever begin
      @(negedge clk_in);
      if (bus2.sync) idx = 0;
      else if (ps && !bus2.SCLK && idx < 16) begin
        bus2.audio_in = adc_word[15-idx];
        idx++;
      end
      ps = bus2.SCLK;
    end
  end

  initial begin : adc1
    int   idx;
    logic ps;
    idx = 0; ps = 1'b1; bus1.audio_in = 1'b0;
    forever begin
      @(negedge clk_in);
      if (bus1.sync) idx = 0;
      else if (ps && !bus1.SCLK && idx < 16) begin
        bus1.audio_in = adc_word[15-idx];
        idx++;
      end
      ps = bus1.SCLK;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input string tag, input bit s, input logic [15:0] w,
                           input logic [15:0] exp_a, input int exp_lat, input int exp_slow);
    int          lat, slow, rises;
    bit          got, hold_ok, ps, psync;
    logic [15:0] a0;
    lat = 0; slow = 0; rises = 0; got = 0; hold_ok = 1; ps = 1; psync = 1;
    sel = s; adc_word = w;
    @(negedge clk_in);
    if (s) bus1.nv_echantillon1 = 1'b1;
    else   bus2.nv_echantillon1 = 1'b1;
    @(negedge clk_in);
    bus1.nv_echantillon1 = 1'b0;
    bus2.nv_echantillon1 = 1'b0;
    a0 = o_audio;
    for (int n = 1; n <= 200 && !got; n++) begin
      if (!o_sync) slow++;
      if (!ps && o_sclk && !psync) rises++;
      if (o_pret) begin
        got = 1; lat = n;
      end else if (o_audio !== a0) hold_ok = 0;
      ps = o_sclk; psync = o_sync;
      if (!got) @(negedge clk_in);
    end
    chk({tag, "_latency"},  lat,     exp_lat);
    chk({tag, "_sync_low"}, slow,    exp_slow);
    chk({tag, "_rises"},    rises,   16);
    chk({tag, "_hold"},     hold_ok, 1);
    chk({tag, "_audio"},    o_audio, exp_a);
    @(negedge clk_in);
    chk({tag, "_pret_1cyc"}, o_pret, 0);
    for (int i = 0; i < 40 && o_occ; i++) @(negedge clk_in);
    chk({tag, "_idle"}, o_occ, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   deb, shigh, olow, nend;
    bit   seen_high, got;
    vt[0] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 65, 64};
    vt[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 16'h7FFF, 65, 64};
    vt[2] = '{1'b0, 16'h0000, 16'h0000, 16'h8000, 65, 64};
    vt[3] = '{1'b0, 16'h1234, 16'h1234, 16'h9234, 65, 64};
    vt[4] = '{1'b1, 16'h0001, 16'h0001, 16'h8001, 33, 32};
    vt[5] = '{1'b1, 16'hC3A0, 16'hC3A0, 16'h43A0, 33, 32};

    // Reset with requests pending: nothing may be accepted.
    reset = 1'b0; sel = 0; adc_word = '0;
    bus2.nv_echantillon1 = 1'b1;
    bus1.nv_echantillon1 = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("rst_sclk",   bus2.SCLK, 1);
    chk("rst_sync",   bus2.sync, 1);
    chk("rst_audio",  bus2.audio_out, 0);
    chk("rst_pret",   bus2.echantillon_pret, 0);
    chk("rst_occupe", bus2.occupe, 0);
    chk("rst_debord", bus2.debordement, 0);
    chk("rst_occupe1", bus1.occupe, 0);
    chk("rst_sync1",   bus1.sync, 1);
    bus2.nv_echantillon1 = 1'b0;
    bus1.nv_echantillon1 = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk_in);

    for (int i = 0; i < 6; i++)
      run_frame($sformatf("vec%0d", i), vt[i].div1, vt[i].adc,
                SIGNE ? vt[i].sgn : vt[i].raw, vt[i].lat, vt[i].slow);

    // Request held high across two frames on the DIV_SCLK=2 unit.
    sel = 0; adc_word = 16'h1234;
    @(negedge clk_in);
    bus2.nv_echantillon1 = 1'b1;
    for (int i = 0; i < 10 && !bus2.occupe; i++) @(negedge clk_in);
    deb = 0; shigh = 0; olow = 0; seen_high = 0; nend = 0;
    for (int n = 1; n < 200; n++) begin
      nend = n;
      if (bus2.debordement) deb++;
      if (!bus2.occupe) olow++;
      if (bus2.sync) begin
        shigh++; seen_high = 1;
      end else if (seen_high) break;
      @(negedge clk_in);
    end
    chk("cont_debord_cnt", deb,   66);
    chk("cont_occ_low",    olow,  1);
    chk("cont_sync_gap",   shigh, 3);
    chk("cont_reaccept",   nend,  68);
    bus2.nv_echantillon1 = 1'b0;
    for (int i = 0; i < 200 && bus2.occupe; i++) @(negedge clk_in);
    chk("cont_idle",  bus2.occupe, 0);
    chk("cont_audio", bus2.audio_out, SIGNE ? 16'h9234 : 16'h1234);

    // Reset on the edge of the 8th SCLK rise aborts the frame.
    sel = 0; adc_word = 16'hFFFF;
    @(negedge clk_in);
    bus2.nv_echantillon1 = 1'b1;
    @(negedge clk_in);
    bus2.nv_echantillon1 = 1'b0;
    repeat (29) @(negedge clk_in);
    chk("abort_pre_sclk", bus2.SCLK, 0);
    chk("abort_pre_sync", bus2.sync, 0);
    reset = 1'b0;
    @(negedge clk_in);
    chk("abort_sync",   bus2.sync, 1);
    chk("abort_sclk",   bus2.SCLK, 1);
    chk("abort_occupe", bus2.occupe, 0);
    reset = 1'b1;
    got = 0;
    repeat (80) begin
      if (bus2.echantillon_pret) got = 1;
      @(negedge clk_in);
    end
    chk("abort_no_pret", got, 0);
    chk("abort_audio",   bus2.audio_out, 0);
    run_frame("after_abort", 1'b0, 16'hA5A5, SIGNE ? 16'h25A5 : 16'hA5A5, 65, 64);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
